// File: rtl/key_evt_pkg.sv
// Shared types and timing defaults for the key gesture decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_evt_pkg;

    // Per-key gesture FSM states; explicit encodings keep waveforms readable.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT2     = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } key_state_e;

    // 500 ms long press and 250 ms double-click window at 50 MHz.
    localparam int LONG_CYC_50M = 25_000_000;
    localparam int DBL_CYC_50M  = 12_500_000;

    // Counter width big enough for the larger of the two terminal counts.
    function automatic int cnt_width(input int long_cyc, input int dbl_cyc);
        return $clog2((long_cyc > dbl_cyc) ? long_cyc : dbl_cyc);
    endfunction

endpackage

// File: rtl/key_evt_fsm.sv
// One key's gesture classifier: short press, long press, double click.
// Latency: event pulse registered one cycle after the deciding input cycle.
// Backpressure: none; pulses are fire-and-forget single-cycle strobes.
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_CYC = LONG_CYC_50M,
    parameter int DBL_CYC  = DBL_CYC_50M
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed,
    output logic short_p,
    output logic long_p,
    output logic dbl_p,
    output logic held
);

    localparam int CNT_W = cnt_width(LONG_CYC, DBL_CYC);

    // Terminal counts: reaching them forces a state exit, so cnt never wraps.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic             held_q, held_d;

    // Next-state, counter and event decode for one key.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS1;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS1: begin
                if (pressed) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = LONG_HELD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    // Release before the long threshold opens the double-click window.
                    state_d = WAIT2;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT2: begin
                if (pressed) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS2: begin
                // No timeout here: a held second press only ever ends as a double.
                if (!pressed) begin
                    dbl_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            LONG_HELD: begin
                if (!pressed) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        held_d = (state_d == LONG_HELD);
    end

    // State, counter and registered outputs; reset discards any gesture in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            held_q  <= held_d;
        end
    end

    assign short_p = short_q;
    assign long_p  = long_q;
    assign dbl_p   = dbl_q;
    assign held    = held_q;

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced active-low key levels into per-key gesture event pulses.
// Latency: 2 clocks from key_n to event pulse (input register + FSM register).
// Backpressure: none; consumers must take pulses in the cycle they appear.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int N_KEYS   = 3,
    parameter int LONG_CYC = LONG_CYC_50M,
    parameter int DBL_CYC  = DBL_CYC_50M
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] short_p,
    output logic [N_KEYS-1:0] long_p,
    output logic [N_KEYS-1:0] dbl_p,
    output logic [N_KEYS-1:0] held
);

    logic [N_KEYS-1:0] key_q, key_d;
    logic [N_KEYS-1:0] pressed;

    // Input capture is a plain copy of the debounced levels.
    always_comb begin
        key_d = key_n;
    end

    // Input register resets to released so a key held through reset is a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '1;
        end else begin
            key_q <= key_d;
        end
    end

    assign pressed = ~key_q;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_evt_fsm #(
            .LONG_CYC (LONG_CYC),
            .DBL_CYC  (DBL_CYC)
        ) u_fsm (
            .clk      (clk),
            .rst_n    (rst_n),
            .pressed  (pressed[i]),
            .short_p  (short_p[i]),
            .long_p   (long_p[i]),
            .dbl_p    (dbl_p[i]),
            .held     (held[i])
        );
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CYC=8, DBL_CYC=5.
// Tick t = t-th rising edge after clearing the logs; outputs sampled 1 time unit after it.
// A key_n value driven for tick t is key_q cycle t, so its decision shows at tick t+1.
module tb_key_event_decoder;

    localparam int NK = 3;
    localparam int LC = 8;
    localparam int DC = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] short_p, long_p, dbl_p, held;

    int errors = 0;
    int checks = 0;

    logic [NK-1:0] log_s [64];
    logic [NK-1:0] log_l [64];
    logic [NK-1:0] log_d [64];
    logic [NK-1:0] log_h [64];
    int            ns [NK];
    int            nl [NK];
    int            nd [NK];
    int            t;

    always #5 clk = ~clk;

    key_event_decoder #(
        .N_KEYS   (NK),
        .LONG_CYC (LC),
        .DBL_CYC  (DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .short_p  (short_p),
        .long_p   (long_p),
        .dbl_p    (dbl_p),
        .held     (held)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_logs();
        t = 0;
        for (int i = 0; i < 64; i++) begin
            log_s[i] = '0;
            log_l[i] = '0;
            log_d[i] = '0;
            log_h[i] = '0;
        end
        for (int k = 0; k < NK; k++) begin
            ns[k] = 0;
            nl[k] = 0;
            nd[k] = 0;
        end
    endtask

    // Hold key_n for n ticks, logging and counting every output pulse.
    task automatic drive(input logic [NK-1:0] kn, input int n);
        for (int c = 0; c < n; c++) begin
            key_n = kn;
            @(posedge clk);
            #1;
            t++;
            if (t < 64) begin
                log_s[t] = short_p;
                log_l[t] = long_p;
                log_d[t] = dbl_p;
                log_h[t] = held;
            end
            for (int k = 0; k < NK; k++) begin
                ns[k] += int'(short_p[k]);
                nl[k] += int'(long_p[k]);
                nd[k] += int'(dbl_p[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("rst_short", int'(short_p), 0);
        check("rst_long",  int'(long_p),  0);
        check("rst_dbl",   int'(dbl_p),   0);
        check("rst_held",  int'(held),    0);
        rst_n = 1'b1;
        drive(3'b111, 3);

        // Short press on key0: released from cycle 4, short_p at 4+5.
        clr_logs();
        drive(3'b110, 3);
        drive(3'b111, 10);
        check("short_cnt",    ns[0], 1);
        check("short_early",  int'(log_s[8]), 0);
        check("short_at9",    int'(log_s[9]), 3'b001);
        check("short_nolong", nl[0] + nl[1] + nl[2], 0);
        check("short_nodbl",  nd[0] + nd[1] + nd[2], 0);

        // Long press on key1 for 20 cycles: long_p at 1+8, held until release+1.
        clr_logs();
        drive(3'b101, 20);
        drive(3'b111, 5);
        check("long_early", int'(log_l[8]), 0);
        check("long_at9",   int'(log_l[9]), 3'b010);
        check("long_cnt",   nl[1], 1);
        check("held_pre",   int'(log_h[8]), 0);
        check("held_rise",  int'(log_h[9]), 3'b010);
        check("held_last",  int'(log_h[21]), 3'b010);
        check("held_fall",  int'(log_h[22]), 0);
        check("long_norel", ns[1] + nd[1], 0);

        // 7 pressed cycles: release at the long boundary, short at 8+5.
        clr_logs();
        drive(3'b110, 7);
        drive(3'b111, 10);
        check("b7_nolong", nl[0], 0);
        check("b7_short",  int'(log_s[13]), 3'b001);
        check("b7_scnt",   ns[0], 1);

        // 8 pressed cycles: long_p at 9, no short afterwards.
        clr_logs();
        drive(3'b110, 8);
        drive(3'b111, 10);
        check("b8_long",    int'(log_l[9]), 3'b001);
        check("b8_lcnt",    nl[0], 1);
        check("b8_noshort", ns[0], 0);

        // Double click: press 2, release 4, press 2, release -> dbl_p at 10.
        clr_logs();
        drive(3'b110, 2);
        drive(3'b111, 4);
        drive(3'b110, 2);
        drive(3'b111, 8);
        check("dbl_at10",    int'(log_d[10]), 3'b001);
        check("dbl_cnt",     nd[0], 1);
        check("dbl_noshort", ns[0], 0);

        // Gap of 5 released cycles: two shorts (at 8 and 15), no double.
        clr_logs();
        drive(3'b110, 2);
        drive(3'b111, 5);
        drive(3'b110, 2);
        drive(3'b111, 10);
        check("gap_short1", int'(log_s[8]), 3'b001);
        check("gap_short2", int'(log_s[15]), 3'b001);
        check("gap_scnt",   ns[0], 2);
        check("gap_nodbl",  nd[0], 0);

        // Keys 0 and 2 short, key1 long, all starting together.
        clr_logs();
        drive(3'b000, 3);
        drive(3'b101, 9);
        drive(3'b111, 4);
        check("sim_short", int'(log_s[9]), 3'b101);
        check("sim_long",  int'(log_l[9]), 3'b010);
        check("sim_k1s",   ns[1], 0);
        check("sim_nodbl", nd[0] + nd[1] + nd[2], 0);

        // Reset with key0 in WAIT2 and key1 in LONG_HELD.
        clr_logs();
        drive(3'b101, 6);
        drive(3'b100, 2);
        drive(3'b101, 2);
        check("mid_held_pre", int'(log_h[10]), 3'b010);
        rst_n = 1'b0;
        #1;
        check("mid_short", int'(short_p), 0);
        check("mid_long",  int'(long_p),  0);
        check("mid_dbl",   int'(dbl_p),   0);
        check("mid_held",  int'(held),    0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Key1 held through reset release: fresh press, long_p at 9.
        clr_logs();
        drive(3'b101, 12);
        drive(3'b111, 8);
        check("post_long_early", int'(log_l[8]), 0);
        check("post_long_at9",   int'(log_l[9]), 3'b010);
        check("post_lcnt",       nl[1], 1);
        check("post_noshort",    ns[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Gesture classifier downstream of the switch debouncer: takes the debounced, active-low key levels and turns each key's press pattern into one single-cycle event pulse per gesture (short press, long press or double click). It feeds the LED and mode-control logic, which then respond to gestures rather than raw level changes. Keys are independent; one FSM runs per key.

## Interface
- `N_KEYS`, 3: number of keys.
- `LONG_CYC`, 25_000_000: pressed cycles that make a long press (500 ms at 50 MHz); ≥2.
- `DBL_CYC`, 12_500_000: released cycles after a first press that make the double-click window (250 ms); ≥2.
- `clk  in  1`: 50 MHz system clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `key_n  in  N_KEYS`: debounced key levels, 0 = pressed, already synchronous to `clk`.
- `short_p  out  N_KEYS`: 1-cycle pulse per completed short press.
- `long_p  out  N_KEYS`: 1-cycle pulse when a press reaches `LONG_CYC`.
- `dbl_p  out  N_KEYS`: 1-cycle pulse per completed double click.
- `held  out  N_KEYS`: level, 1 while the key is in `LONG_HELD`.

## Operation
- Input register `key_q <= key_n`. Reset value is all ones (released). The FSMs act on `key_q`.
- Per-key FSM and counter `cnt`:
  - **IDLE**: pressed → PRESS1, `cnt`=1.
  - **PRESS1**:
    - pressed and `cnt`==`LONG_CYC`-1 → raise `long_p`, go LONG_HELD.
    - pressed otherwise → `cnt`++.
    - released → WAIT2, `cnt`=1.
  - **WAIT2**:
    - pressed → PRESS2.
    - released and `cnt`==`DBL_CYC`-1 → raise `short_p`, go IDLE.
    - released otherwise → `cnt`++.
  - **PRESS2**: released → raise `dbl_p`, go IDLE. There is no timeout; a held second press never produces `long_p`.
  - **LONG_HELD**: released → IDLE. No further pulses while held; no auto-repeat.
- Exactly one event per gesture. A triple click gives `dbl_p` and then starts a new gesture.
- `cnt` width is `$clog2(max(LONG_CYC,DBL_CYC))`. It never wraps, because every terminal value forces a state exit.
- Simultaneous gestures on different keys give pulses on multiple bits in the same cycle. There is no arbitration.
- All outputs are registered. Reset values: `short_p`/`long_p`/`dbl_p`/`held` = 0, all FSMs IDLE, `cnt` = 0.
- **Reset mid-operation**: the gesture in progress is discarded with no pulse. A key held through reset is seen as a fresh press on the first cycle after reset release.

## Timing
- `key_q` lags `key_n` by 1 clock. Each event pulse is high in the cycle after the deciding `key_q` cycle, so the total latency from `key_n` is 2 clocks.
- **Long**: first pressed `key_q` cycle p, pressed through p+`LONG_CYC`-1 → `long_p` high in cycle p+`LONG_CYC`. `held` rises in that same cycle.
- **Release at the long boundary**: if the key is released at `key_q` cycle p+`LONG_CYC`-1, no `long_p`; the gesture takes the short/double path.
- **Short**: first released cycle r, released through r+`DBL_CYC`-1 → `short_p` high in cycle r+`DBL_CYC`.
- **Double-click window**: a press at any cycle r..r+`DBL_CYC`-1 → PRESS2. A press at r+`DBL_CYC` is a new gesture after `short_p`.
- **Double**: first released cycle q in PRESS2 → `dbl_p` high in cycle q+1.
- `held` falls in the cycle after the first released `key_q` cycle.

## Structure
- Package `key_evt_pkg`: FSM state enum (`IDLE`, `PRESS1`, `WAIT2`, `PRESS2`, `LONG_HELD`) and default timing constants `LONG_CYC_50M`, `DBL_CYC_50M`.
- Sub-module `key_evt_fsm`: one key's FSM, counter and registered pulses, instantiated `N_KEYS` times in a generate loop.
- The top level holds only `key_q` and the generate loop.

## Test plan
All scenarios use `LONG_CYC`=8, `DBL_CYC`=5.
- **Short press**: key0 pressed 3 cycles then released → one `short_p[0]` pulse 5 cycles after release is seen on `key_q`; no `long_p` or `dbl_p`.
- **Long press**: key1 held 20 cycles → `long_p[1]` at pressed-cycle 8. `held[1]` is high from that cycle until 1 cycle after release. No pulse on release.
- **Long-press boundary**: press for exactly 7 cycles → no `long_p`, `short_p` follows. Press for exactly 8 cycles → `long_p`, no `short_p`.
- **Double click**: press 2, release 4, press 2, release → one `dbl_p[0]` the cycle after the second release. Repeat with a gap of 5 released cycles → `short_p` twice and no `dbl_p`.
- **Simultaneous keys**: key0 and key2 given identical short presses → `short_p`=3'b101 in the same cycle. Key1 long-pressed concurrently → independent `long_p[1]`.
- **Reset mid-gesture**: assert `rst_n` during WAIT2 → all outputs 0 and no `short_p`. Key held through reset release → `long_p` 8 pressed cycles after reset release.
